generate_subkeys: RTL and testbench



---
 rtl/des_pkg.sv | 48 ++++
 rtl/generate_subkeys_if.sv | 46 ++++
 rtl/des_pc2_round.sv | 31 +++
 rtl/generate_subkeys.sv | 71 +++++++
 tb/tb_generate_subkeys.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// ============================================================================
// des_pkg : DES key-schedule tables, types and rotation helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package des_pkg;

   typedef logic [27:0] half_key_t;
   typedef logic [47:0] subkey_t;

   localparam int unsigned C_NUM_ROUNDS = 16;

   // FIPS 46-3 tables, 1-based, MSB-first DES bit numbering.
   localparam int unsigned C_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned C_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Running total of the per-round left-rotation schedule.
   localparam int unsigned C_SHIFT_CUM [16] = '{
      1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28
   };

   function automatic half_key_t rotl28(input half_key_t h, input int unsigned n);
      return (h << n) | (h >> (28 - n));
   endfunction

endpackage

`default_nettype wire

// File: rtl/generate_subkeys_if.sv
// ============================================================================
// generate_subkeys_if : cipher key in, sixteen round subkeys out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface generate_subkeys_if;
   import des_pkg::*;

   logic [63:0] key;
   subkey_t     sub_key1;
   subkey_t     sub_key2;
   subkey_t     sub_key3;
   subkey_t     sub_key4;
   subkey_t     sub_key5;
   subkey_t     sub_key6;
   subkey_t     sub_key7;
   subkey_t     sub_key8;
   subkey_t     sub_key9;
   subkey_t     sub_key10;
   subkey_t     sub_key11;
   subkey_t     sub_key12;
   subkey_t     sub_key13;
   subkey_t     sub_key14;
   subkey_t     sub_key15;
   subkey_t     sub_key16;

   modport master (
      output key,
      input  sub_key1,  sub_key2,  sub_key3,  sub_key4,
      input  sub_key5,  sub_key6,  sub_key7,  sub_key8,
      input  sub_key9,  sub_key10, sub_key11, sub_key12,
      input  sub_key13, sub_key14, sub_key15, sub_key16
   );

   modport slave (
      input  key,
      output sub_key1,  sub_key2,  sub_key3,  sub_key4,
      output sub_key5,  sub_key6,  sub_key7,  sub_key8,
      output sub_key9,  sub_key10, sub_key11, sub_key12,
      output sub_key13, sub_key14, sub_key15, sub_key16
   );

endinterface

`default_nettype wire

// File: rtl/des_pc2_round.sv
// ============================================================================
// des_pc2_round : rotate C0/D0 by a fixed cumulative amount, then apply PC-2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module des_pc2_round
   import des_pkg::*;
#(
   parameter int unsigned SHIFT = 1
) (
   input  wire half_key_t i_c0,
   input  wire half_key_t i_d0,
   output subkey_t        o_sub_key
);

   half_key_t   w_c;
   half_key_t   w_d;
   logic [55:0] w_cd;

   assign w_c  = rotl28(i_c0, SHIFT);
   assign w_d  = rotl28(i_d0, SHIFT);
   assign w_cd = {w_c, w_d};

   for (genvar i = 0; i < 48; i++) begin : g_pc2
      assign o_sub_key[47-i] = w_cd[56-C_PC2[i]];
   end

endmodule

`default_nettype wire

// File: rtl/generate_subkeys.sv
// ============================================================================
// generate_subkeys : DES key schedule, all sixteen subkeys registered in parallel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module generate_subkeys
   import des_pkg::*;
(
   input  wire               clk,
   input  wire               rst_n,
   generate_subkeys_if.slave bus
);

   logic [55:0] w_cd0;
   half_key_t   w_c0;
   half_key_t   w_d0;
   logic        w_unused_parity;

   for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign w_cd0[55-i] = bus.key[64-C_PC1[i]];
   end

   assign w_c0 = w_cd0[55:28];
   assign w_d0 = w_cd0[27:0];

   // DES bits 8,16,...,64 never reach the schedule.
   assign w_unused_parity = ^{bus.key[56], bus.key[48], bus.key[40], bus.key[32],
                              bus.key[24], bus.key[16], bus.key[8],  bus.key[0]};

   for (genvar r = 0; r < C_NUM_ROUNDS; r++) begin : g_round
      subkey_t w_sub_key;
      subkey_t r_sub_key;

      des_pc2_round #(
         .SHIFT (C_SHIFT_CUM[r])
      ) u_pc2 (
         .i_c0      (w_c0),
         .i_d0      (w_d0),
         .o_sub_key (w_sub_key)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sub_key <= '0;
         end else begin
            r_sub_key <= w_sub_key;
         end
      end
   end

   assign bus.sub_key1  = g_round[0].r_sub_key;
   assign bus.sub_key2  = g_round[1].r_sub_key;
   assign bus.sub_key3  = g_round[2].r_sub_key;
   assign bus.sub_key4  = g_round[3].r_sub_key;
   assign bus.sub_key5  = g_round[4].r_sub_key;
   assign bus.sub_key6  = g_round[5].r_sub_key;
   assign bus.sub_key7  = g_round[6].r_sub_key;
   assign bus.sub_key8  = g_round[7].r_sub_key;
   assign bus.sub_key9  = g_round[8].r_sub_key;
   assign bus.sub_key10 = g_round[9].r_sub_key;
   assign bus.sub_key11 = g_round[10].r_sub_key;
   assign bus.sub_key12 = g_round[11].r_sub_key;
   assign bus.sub_key13 = g_round[12].r_sub_key;
   assign bus.sub_key14 = g_round[13].r_sub_key;
   assign bus.sub_key15 = g_round[14].r_sub_key;
   assign bus.sub_key16 = g_round[15].r_sub_key;

endmodule

`default_nettype wire

// File: tb/tb_generate_subkeys.sv
// ============================================================================
// tb_generate_subkeys : directed and random checks of the DES key schedule.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_generate_subkeys;

   localparam logic [63:0] C_KEY_A = 64'h133457799BBCDFF1;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int ROT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   generate_subkeys_if bus ();

   generate_subkeys dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [47:0] obs [16];
   assign obs[0]  = bus.sub_key1;
   assign obs[1]  = bus.sub_key2;
   assign obs[2]  = bus.sub_key3;
   assign obs[3]  = bus.sub_key4;
   assign obs[4]  = bus.sub_key5;
   assign obs[5]  = bus.sub_key6;
   assign obs[6]  = bus.sub_key7;
   assign obs[7]  = bus.sub_key8;
   assign obs[8]  = bus.sub_key9;
   assign obs[9]  = bus.sub_key10;
   assign obs[10] = bus.sub_key11;
   assign obs[11] = bus.sub_key12;
   assign obs[12] = bus.sub_key13;
   assign obs[13] = bus.sub_key14;
   assign obs[14] = bus.sub_key15;
   assign obs[15] = bus.sub_key16;

   // Round-by-round reference: K(n+1) sits at [767-48n -: 48].
   function automatic logic [767:0] ref_model(input logic [63:0] k);
      logic [55:0]  cd;
      logic [27:0]  c;
      logic [27:0]  d;
      logic [47:0]  sk;
      logic [767:0] all;
      all = '0;
      for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_T[i])];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < ROT_T[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) sk[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
         all[767 - 48*r -: 48] = sk;
      end
      return all;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.key = C_KEY_A;
      rst_n   = 1'b0;
      repeat (3) tick();
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== 48'h0) begin
            n_fail++;
            $display("FAIL reset K%0d: got %h expected %h", n + 1, obs[n], 48'h0);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_known_vector;
      logic [767:0] exp;
      bus.key = C_KEY_A;
      tick();
      n_cmp++;
      if (obs[0] !== 48'h1B02EFFC7072) begin
         n_fail++;
         $display("FAIL known K1: got %h expected %h", obs[0], 48'h1B02EFFC7072);
      end
      n_cmp++;
      if (obs[1] !== 48'h79AED9DBC9E5) begin
         n_fail++;
         $display("FAIL known K2: got %h expected %h", obs[1], 48'h79AED9DBC9E5);
      end
      n_cmp++;
      if (obs[15] !== 48'hCB3D8B0E17F5) begin
         n_fail++;
         $display("FAIL known K16: got %h expected %h", obs[15], 48'hCB3D8B0E17F5);
      end
      exp = ref_model(C_KEY_A);
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== exp[767 - 48*n -: 48]) begin
            n_fail++;
            $display("FAIL known_model K%0d: got %h expected %h", n + 1, obs[n], exp[767 - 48*n -: 48]);
         end
      end
   endtask

   task automatic test_const_keys;
      logic [63:0] keys [3];
      logic [47:0] fill [3];
      keys = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0101010101010101};
      fill = '{48'h0, 48'hFFFFFFFFFFFF, 48'h0};
      for (int t = 0; t < 3; t++) begin
         bus.key = keys[t];
         tick();
         for (int n = 0; n < 16; n++) begin
            n_cmp++;
            if (obs[n] !== fill[t]) begin
               n_fail++;
               $display("FAIL const key=%h K%0d: got %h expected %h", keys[t], n + 1, obs[n], fill[t]);
            end
         end
      end
   endtask

   task automatic test_parity;
      logic [767:0] exp;
      exp = ref_model(C_KEY_A);
      for (int j = 0; j < 8; j++) begin
         bus.key = C_KEY_A ^ (64'h1 << (8 * j));
         tick();
         for (int n = 0; n < 16; n++) begin
            n_cmp++;
            if (obs[n] !== exp[767 - 48*n -: 48]) begin
               n_fail++;
               $display("FAIL parity bit%0d K%0d: got %h expected %h", 8 * j, n + 1, obs[n], exp[767 - 48*n -: 48]);
            end
         end
      end
   endtask

   task automatic test_latency;
      logic [767:0] exp_a;
      logic [767:0] exp_b;
      logic [63:0]  key_b;
      key_b   = 64'h0E329232EA6D0D73;
      exp_a   = ref_model(C_KEY_A);
      exp_b   = ref_model(key_b);
      bus.key = C_KEY_A;
      tick();
      bus.key = key_b;
      #2;
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== exp_a[767 - 48*n -: 48]) begin
            n_fail++;
            $display("FAIL latency_old K%0d: got %h expected %h", n + 1, obs[n], exp_a[767 - 48*n -: 48]);
         end
      end
      tick();
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== exp_b[767 - 48*n -: 48]) begin
            n_fail++;
            $display("FAIL latency_new K%0d: got %h expected %h", n + 1, obs[n], exp_b[767 - 48*n -: 48]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0]  keys [6];
      logic [767:0] exp;
      keys = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hAAAAAAAAAAAAAAAA,
               64'h5555555555555555, 64'h8000000000000000, 64'h0000000000000002};
      bus.key = keys[0];
      tick();
      for (int t = 0; t < 6; t++) begin
         // Next key goes in immediately; outputs must still reflect keys[t].
         if (t < 5) bus.key = keys[t + 1];
         exp = ref_model(keys[t]);
         for (int n = 0; n < 16; n++) begin
            n_cmp++;
            if (obs[n] !== exp[767 - 48*n -: 48]) begin
               n_fail++;
               $display("FAIL b2b key=%h K%0d: got %h expected %h", keys[t], n + 1, obs[n], exp[767 - 48*n -: 48]);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset;
      logic [767:0] exp;
      exp     = ref_model(C_KEY_A);
      bus.key = C_KEY_A;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset K%0d: got %h expected %h", n + 1, obs[n], 48'h0);
         end
      end
      tick();
      n_cmp++;
      if (obs[0] !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_held K1: got %h expected %h", obs[0], 48'h0);
      end
      #2;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (obs[0] !== 48'h0) begin
         n_fail++;
         $display("FAIL release_no_edge K1: got %h expected %h", obs[0], 48'h0);
      end
      tick();
      for (int n = 0; n < 16; n++) begin
         n_cmp++;
         if (obs[n] !== exp[767 - 48*n -: 48]) begin
            n_fail++;
            $display("FAIL after_release K%0d: got %h expected %h", n + 1, obs[n], exp[767 - 48*n -: 48]);
         end
      end
   endtask

   task automatic test_random;
      logic [63:0]  k;
      logic [767:0] exp;
      for (int t = 0; t < 1000; t++) begin
         k       = {$urandom(), $urandom()};
         bus.key = k;
         tick();
         exp = ref_model(k);
         for (int n = 0; n < 16; n++) begin
            n_cmp++;
            if (obs[n] !== exp[767 - 48*n -: 48]) begin
               n_fail++;
               $display("FAIL random key=%h K%0d: got %h expected %h", k, n + 1, obs[n], exp[767 - 48*n -: 48]);
            end
         end
      end
   endtask

   initial begin
      bus.key = '0;
      test_reset();
      test_known_vector();
      test_const_keys();
      test_parity();
      test_latency();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
